// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
//   uart_state_t    : transmitter FSM states
//   TX_ADDR_DEFAULT : default transmit-data store address
//   BYTE_W          : width of one serial payload byte
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam logic [15:0] TX_ADDR_DEFAULT = 16'hFF00;
  localparam int unsigned BYTE_W          = 8;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered pointers and occupancy count.
// A push while full is accepted only when a pop happens on the same edge.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   push, din        : enqueue request and data
//   pop              : dequeue request (ignored while empty)
//   dout             : head entry, decoded from registered pointer
//   full, empty      : occupancy flags
//   count            : number of stored entries, 0..DEPTH
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage array; no reset needed since validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push && !reset) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU stores to TX_ADDR queue bytes in a
// FIFO, and the FSM serialises them LSB first with one start and one stop bit.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   memwrite   : CPU store strobe
//   dataadr    : CPU store address
//   writedata  : CPU store data, low byte transmitted
//   tx         : serial line, idle high
//   tx_busy    : frame in progress or bytes queued
//   fifo_full  : FIFO holds FIFO_DEPTH entries
//   overflow   : sticky, a store was dropped on a full FIFO
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter int unsigned   n            = 16,
  parameter int unsigned   CLKS_PER_BIT = 16,
  parameter int unsigned   FIFO_DEPTH   = 4,
  parameter logic [n-1:0]  TX_ADDR      = n'(TX_ADDR_DEFAULT)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         memwrite,
  input  logic [n-1:0] dataadr,
  input  logic [n-1:0] writedata,
  output logic         tx,
  output logic         tx_busy,
  output logic         fifo_full,
  output logic         overflow
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  uart_state_t       state;
  logic [BAUD_W-1:0] baud;
  logic [2:0]        bit_idx;
  logic [BYTE_W-1:0] shift;

  logic              push;
  logic              pop;
  logic [BYTE_W-1:0] head;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic              bit_end;
  logic              unused_hi;

  assign unused_hi = ^writedata[n-1:BYTE_W];

  assign push    = memwrite && (dataadr == TX_ADDR);
  assign bit_end = (baud == BAUD_LAST);
  // Pop on leaving IDLE, or at the end of a stop bit to chain frames gap-free.
  assign pop     = !empty && ((state == IDLE) || ((state == STOP) && bit_end));

  sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (writedata[BYTE_W-1:0]),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (empty),
    .count (count)
  );

  assign tx_busy = (state != IDLE) || (count != '0);

  // Transmit FSM; tx is updated alongside each state transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push && fifo_full && !pop) overflow <= 1'b1;

      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!empty) begin
            shift <= head;
            baud  <= '0;
            state <= START;
            tx    <= 1'b0;
          end
        end

        START: begin
          if (bit_end) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= DATA;
            tx      <= shift[0];
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end

        DATA: begin
          if (bit_end) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[BYTE_W-1:1]};
              tx      <= shift[1];
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end

        STOP: begin
          if (bit_end) begin
            baud <= '0;
            if (!empty) begin
              shift <= head;
              state <= START;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// The reference model tracks a byte queue and a frame position 0..10*CPB-1,
// deriving the expected line level from the 8N1 frame layout.
module tb_mmio_uart_tx;

  localparam int unsigned N     = 16;
  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned FRAME = 10 * CPB;
  localparam logic [15:0] ADDR  = 16'hFF00;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          memwrite = 1'b0;
  logic [N-1:0]  dataadr = '0;
  logic [N-1:0]  writedata = '0;
  logic          tx;
  logic          tx_busy;
  logic          fifo_full;
  logic          overflow;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [7:0] mq[$];
  bit         m_active = 1'b0;
  int         m_pos = 0;
  logic [7:0] m_byte = '0;
  bit         m_ovf = 1'b0;

  mmio_uart_tx #(
    .n            (N),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .TX_ADDR      (ADDR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .tx        (tx),
    .tx_busy   (tx_busy),
    .fifo_full (fifo_full),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic exp_tx();
    int k;
    if (!m_active) return 1'b1;
    k = m_pos / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[k-1];
    return 1'b1;
  endfunction

  task automatic model_edge(input bit rst, input bit wr, input logic [15:0] a,
                            input logic [7:0] d);
    bit do_pop;
    bit hit;
    bit accept;
    if (rst) begin
      mq.delete();
      m_active = 1'b0;
      m_pos    = 0;
      m_ovf    = 1'b0;
      return;
    end
    do_pop = 1'b0;
    if (!m_active) begin
      if (mq.size() > 0) do_pop = 1'b1;
    end else if (m_pos == FRAME - 1) begin
      if (mq.size() > 0) do_pop = 1'b1;
      else m_active = 1'b0;
    end else begin
      m_pos++;
    end
    hit    = wr && (a == ADDR);
    accept = hit && ((mq.size() < DEPTH) || do_pop);
    if (hit && !accept) m_ovf = 1'b1;
    if (do_pop) begin
      m_byte   = mq.pop_front();
      m_active = 1'b1;
      m_pos    = 0;
    end
    if (accept) mq.push_back(d);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    check("tx",        8'(tx),        8'(exp_tx()));
    check("tx_busy",   8'(tx_busy),   8'(m_active || (mq.size() != 0)));
    check("fifo_full", 8'(fifo_full), 8'(mq.size() == DEPTH));
    check("overflow",  8'(overflow),  8'(m_ovf));
  endtask

  task automatic step(input bit rst, input bit wr, input logic [15:0] a,
                      input logic [15:0] d);
    reset     = rst;
    memwrite  = wr;
    dataadr   = a;
    writedata = d;
    @(posedge clk);
    model_edge(rst, wr, a, d[7:0]);
    #1;
    check_all();
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  initial begin
    // Reset, with a store presented during reset that must be discarded
    step(1'b1, 1'b0, 16'h0000, 16'h0000);
    step(1'b1, 1'b1, ADDR, 16'h00EE);
    idle(3);

    // Single byte A5, explicit start-bit latency
    step(1'b0, 1'b1, ADDR, 16'h00A5);
    idle(1);
    check("latency_tx_low", 8'(tx), 8'h00);
    idle(44);
    check("single_done_busy", 8'(tx_busy), 8'h00);

    // Address filter
    step(1'b0, 1'b1, 16'hFF02, 16'h0055);
    idle(50);
    check("filter_busy", 8'(tx_busy), 8'h00);

    // Back-to-back frames
    step(1'b0, 1'b1, ADDR, 16'h0001);
    step(1'b0, 1'b1, ADDR, 16'h0002);
    idle(90);

    // Overflow: 0x10..0x15 on consecutive cycles
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, ADDR, 16'(16'h0010 + i));
    check("ovf_set", 8'(overflow), 8'h01);
    check("ovf_full", 8'(fifo_full), 8'h01);
    idle(5 * FRAME + 10);
    check("ovf_sticky", 8'(overflow), 8'h01);

    // Mid-frame reset during data bit 3
    step(1'b0, 1'b1, ADDR, 16'h00C3);
    for (int i = 0; i < 100 && !(m_active && m_pos == 4 * CPB + 1); i++) idle(1);
    check("midreset_reached", 8'(m_active && m_pos == 4 * CPB + 1), 8'h01);
    step(1'b1, 1'b0, 16'h0000, 16'h0000);
    check("midreset_tx", 8'(tx), 8'h01);
    check("midreset_busy", 8'(tx_busy), 8'h00);
    check("midreset_ovf", 8'(overflow), 8'h00);
    idle(50);

    // Push while full at the STOP-to-START pop edge
    step(1'b0, 1'b1, ADDR, 16'h0030);
    for (int i = 1; i < 5; i++) step(1'b0, 1'b1, ADDR, 16'(16'h0030 + i));
    check("pp_full", 8'(fifo_full), 8'h01);
    for (int i = 0; i < 200 && !(m_active && m_pos == FRAME - 1); i++) idle(1);
    check("pp_reached", 8'(m_active && m_pos == FRAME - 1), 8'h01);
    step(1'b0, 1'b1, ADDR, 16'h0035);
    check("pp_ovf_clear", 8'(overflow), 8'h00);
    check("pp_still_full", 8'(fifo_full), 8'h01);
    idle(5 * FRAME + 10);

    // Randomised traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      bit          r;
      bit          w;
      logic [15:0] a;
      r = ($urandom_range(0, 249) == 0);
      w = ($urandom_range(0, 15) < 2);
      a = ($urandom_range(0, 3) != 0) ? ADDR : 16'($urandom);
      step(r, w, a, 16'($urandom));
    end
    idle(DEPTH * FRAME + FRAME + 10);
    check("final_busy", 8'(tx_busy), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
